id_stage: RTL and testbench

Decode/operand-fetch stage that sits directly upstream of the ALU. It accepts 32-bit RV32I instructions over a valid/ready handshake and decodes OP and OP-IMM. It reads operands from an internal 32x32 register file and presents registered `func3`/`func7`/`rs1_data`/`rs2_data`/`rd` to the execute stage. A scoreboard stalls read-after-write hazards until the matching writeback arrives.

---
 rtl/rv_pkg.sv | 33 +++
 rtl/id_stage_if.sv | 28 ++
 rtl/reg_file.sv | 50 +++++
 rtl/id_stage.sv | 123 ++++++++++++
 tb/tb_id_stage.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions used by the ID stage and the ALU side.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        OPK_OP,
        OPK_OP_IMM,
        OPK_OTHER
    } op_kind_e;

    // Decoded operation handed from decode to execute.
    typedef struct packed {
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [4:0]      rd;
    } decoded_op_t;

    function automatic op_kind_e classify(input logic [6:0] opcode);
        if (opcode == OPC_OP)          return OPK_OP;
        else if (opcode == OPC_OP_IMM) return OPK_OP_IMM;
        else                           return OPK_OTHER;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Instruction, execute and writeback channels of the ID stage.
interface id_stage_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;
    logic                  ex_valid;
    logic                  ex_ready;
    logic [2:0]            ex_func3;
    logic [6:0]            ex_func7;
    logic [DATA_WIDTH-1:0] ex_rs1_data;
    logic [DATA_WIDTH-1:0] ex_rs2_data;
    logic [4:0]            ex_rd;
    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

    modport master (
        output instr_valid, instr, ex_ready, wb_valid, wb_rd, wb_data,
        input  instr_ready, ex_valid, ex_func3, ex_func7, ex_rs1_data, ex_rs2_data, ex_rd
    );

    modport slave (
        input  instr_valid, instr, ex_ready, wb_valid, wb_rd, wb_data,
        output instr_ready, ex_valid, ex_func3, ex_func7, ex_rs1_data, ex_rs2_data, ex_rd
    );
endinterface

// File: rtl/reg_file.sv
// 2-read / 1-write register file, x0 hard-wired to zero, write-to-read bypass.
module reg_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_COUNT  = 32,
    localparam int unsigned IDX_W     = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      ra1,
    output logic [DATA_WIDTH-1:0] rd1,
    input  logic [IDX_W-1:0]      ra2,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wa,
    input  logic [DATA_WIDTH-1:0] wd
);
    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];

    // Next-state of the array: single write port, x0 writes dropped.
    always_comb begin
        regs_d = regs_q;
        if (we && (wa != '0)) begin
            regs_d[wa] = wd;
        end
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports; a same-cycle write to the read index is forwarded.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) begin
            rd1 = (we && (wa == ra1)) ? wd : regs_q[ra1];
        end
        if (ra2 != '0) begin
            rd2 = (we && (wa == ra2)) ? wd : regs_q[ra2];
        end
    end
endmodule

// File: rtl/id_stage.sv
// Decode/operand-fetch stage: OP / OP-IMM decode, RAW scoreboard, output register.
module id_stage
    import rv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned REG_COUNT  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    id_stage_if.slave   bus,
    output logic [15:0] drop_cnt
);
    logic [4:0]            rs1_idx;
    logic [4:0]            rs2_idx;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;

    logic                  ex_valid_q, ex_valid_d;
    decoded_op_t           ex_op_q, ex_op_d;
    logic [REG_COUNT-1:0]  pending_q, pending_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic [REG_COUNT-1:0]  pend_clr;
    op_kind_e              kind;
    logic                  supported;
    logic                  hazard;
    logic                  instr_ready;
    logic                  accept;
    decoded_op_t           dec;

    assign rs1_idx = bus.instr[19:15];
    assign rs2_idx = bus.instr[24:20];

    reg_file #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_COUNT (REG_COUNT)
    ) u_reg_file (
        .clk  (clk),
        .rst_n(rst_n),
        .ra1  (rs1_idx),
        .rd1  (rs1_val),
        .ra2  (rs2_idx),
        .rd2  (rs2_val),
        .we   (bus.wb_valid),
        .wa   (bus.wb_rd),
        .wd   (bus.wb_data)
    );

    // Decode, hazard check against the post-writeback pending mask, and next state.
    always_comb begin
        kind      = classify(bus.instr[6:0]);
        supported = (kind != OPK_OTHER);

        pend_clr = pending_q;
        if (bus.wb_valid) begin
            pend_clr[bus.wb_rd] = 1'b0;
        end

        hazard = supported &&
                 (pend_clr[rs1_idx] || ((kind == OPK_OP) && pend_clr[rs2_idx]));
        instr_ready = (!ex_valid_q || bus.ex_ready) && !hazard;
        accept      = bus.instr_valid && instr_ready;

        dec.func3    = bus.instr[14:12];
        dec.rd       = bus.instr[11:7];
        dec.rs1_data = rs1_val;
        if (kind == OPK_OP) begin
            dec.func7    = bus.instr[31:25];
            dec.rs2_data = rs2_val;
        end else if ((bus.instr[14:12] == 3'b001) || (bus.instr[14:12] == 3'b101)) begin
            // Shift immediates: only SRAI carries the alternate func7.
            dec.func7    = ((bus.instr[14:12] == 3'b101) && bus.instr[30]) ? F7_ALT : F7_BASE;
            dec.rs2_data = {{(DATA_WIDTH-5){1'b0}}, bus.instr[24:20]};
        end else begin
            dec.func7    = F7_BASE;
            dec.rs2_data = {{(DATA_WIDTH-12){bus.instr[31]}}, bus.instr[31:20]};
        end

        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        if (accept && supported) begin
            ex_valid_d = 1'b1;
            ex_op_d    = dec;
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end

        // Set after clear: a same-cycle clear belongs to the older producer.
        pending_d = pend_clr;
        if (accept && supported && (dec.rd != 5'd0)) begin
            pending_d[dec.rd] = 1'b1;
        end

        drop_cnt_d = drop_cnt_q;
        if (accept && !supported && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Output register, scoreboard and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            pending_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_func3    = ex_op_q.func3;
    assign bus.ex_func7    = ex_op_q.func7;
    assign bus.ex_rs1_data = ex_op_q.rs1_data;
    assign bus.ex_rs2_data = ex_op_q.rs2_data;
    assign bus.ex_rd       = ex_op_q.rd;
    assign drop_cnt        = drop_cnt_q;
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// compared against an architectural reference model.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] drop_cnt;

    id_stage_if #(.DATA_WIDTH(32)) bus ();

    id_stage #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state (architectural view).
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_ex_v;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_rd;
    int unsigned m_drop;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_ex_v = 1'b0; m_f3 = '0; m_f7 = '0; m_a = '0; m_b = '0; m_rd = '0; m_drop = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic wv,
                                           input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (wv && (wr == idx)) return wd;
        return m_regs[idx];
    endfunction

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic er,
                        input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                        input int rdy_chk);
        logic [6:0]  opc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        bit          is_op, is_imm, haz, exp_rdy, acc;
        @(negedge clk);
        bus.instr_valid = v; bus.instr = ins; bus.ex_ready = er;
        bus.wb_valid = wv; bus.wb_rd = wr; bus.wb_data = wd;
        #1;
        check_eq("ex_valid", 32'(bus.ex_valid), 32'(m_ex_v));
        if (m_ex_v) begin
            check_eq("ex_func3", 32'(bus.ex_func3), 32'(m_f3));
            check_eq("ex_func7", 32'(bus.ex_func7), 32'(m_f7));
            check_eq("ex_rs1_data", bus.ex_rs1_data, m_a);
            check_eq("ex_rs2_data", bus.ex_rs2_data, m_b);
            check_eq("ex_rd", 32'(bus.ex_rd), 32'(m_rd));
        end
        check_eq("drop_cnt", 32'(drop_cnt), m_drop);
        check_eq("pending", dut.pending_q, m_pend_vec());

        opc = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20];
        is_op  = (opc == 7'h33);
        is_imm = (opc == 7'h13);
        haz = (is_op || is_imm) &&
              ((m_pend[rs1] && !(wv && wr == rs1)) ||
               (is_op && m_pend[rs2] && !(wv && wr == rs2)));
        exp_rdy = (!m_ex_v || er) && !haz;
        check_eq("instr_ready", 32'(bus.instr_ready), 32'(exp_rdy));
        if (rdy_chk >= 0) check_eq("instr_ready_dir", 32'(bus.instr_ready), 32'(rdy_chk));

        acc = v && exp_rdy;
        if (acc && (is_op || is_imm)) begin
            m_ex_v = 1'b1;
            m_f3 = f3;
            m_rd = rd;
            m_a  = m_read(rs1, wv, wr, wd);
            if (is_op) begin
                m_f7 = ins[31:25];
                m_b  = m_read(rs2, wv, wr, wd);
            end else begin
                m_f7 = (f3 == 3'd5 && ins[30]) ? 7'h20 : 7'h00;
                m_b  = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
            end
        end else if (er) begin
            m_ex_v = 1'b0;
        end
        if (wv) m_pend[wr] = 1'b0;
        if (acc && (is_op || is_imm) && rd != 5'd0) m_pend[rd] = 1'b1;
        if (acc && !(is_op || is_imm) && m_drop < 65535) m_drop++;
        if (wv && wr != 5'd0) m_regs[wr] = wd;
        @(posedge clk);
    endtask

    task automatic expect_ex(input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        #1;
        check_eq("dir_ex_valid", 32'(bus.ex_valid), 32'd1);
        check_eq("dir_func3", 32'(bus.ex_func3), 32'(f3));
        check_eq("dir_func7", 32'(bus.ex_func7), 32'(f7));
        check_eq("dir_rs1_data", bus.ex_rs1_data, a);
        check_eq("dir_rs2_data", bus.ex_rs2_data, b);
        check_eq("dir_rd", 32'(bus.ex_rd), 32'(rd));
    endtask

    task automatic expect_pend(input int idx, input logic val);
        #1;
        check_eq($sformatf("dir_pending[%0d]", idx), 32'(dut.pending_q[idx]), 32'(val));
    endtask

    function automatic logic [31:0] rand_instr();
        int unsigned k;
        logic [4:0]  rd, rs1, rs2, sh;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [31:0] r;
        logic [6:0]  opc;
        k = $urandom_range(0, 9);
        rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7)); sh = 5'($urandom);
        if (k < 4) begin
            return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
        end else if (k < 8) begin
            imm = 12'($urandom);
            if (f3 == 3'd1) imm = {7'h00, sh};
            if (f3 == 3'd5) imm = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, sh};
            return {imm, rs1, f3, rd, 7'h13};
        end
        do opc = 7'($urandom); while (opc == 7'h33 || opc == 7'h13);
        r = $urandom;
        r[6:0] = opc;
        return r;
    endfunction

    initial begin
        logic [4:0]  plist [$];
        logic        wv;
        logic [4:0]  wr;

        model_reset();
        bus.instr_valid = 1'b0; bus.instr = '0; bus.ex_ready = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1);
        // ADDI x1,x0,5
        step(1'b1, 32'h00500093, 1'b1, 1'b0, 5'd0, 32'h0, 1);
        expect_ex(3'b000, 7'h00, 32'd0, 32'd5, 5'd1);
        expect_pend(1, 1'b1);
        // ADD x2,x1,x1 stalls on x1, then is accepted in the writeback cycle.
        step(1'b1, 32'h00108133, 1'b1, 1'b0, 5'd0, 32'h0, 0);
        step(1'b1, 32'h00108133, 1'b1, 1'b1, 5'd1, 32'd5, 1);
        expect_ex(3'b000, 7'h00, 32'd5, 32'd5, 5'd2);
        expect_pend(1, 1'b0);
        expect_pend(2, 1'b1);
        // SRAI x3,x1,4
        step(1'b1, 32'h4040D193, 1'b1, 1'b0, 5'd0, 32'h0, 1);
        expect_ex(3'b101, 7'h20, 32'd5, 32'd4, 5'd3);
        // Hold with ex_ready low, then release: ADDI x5,x0,1 issues.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h00100293, 1'b0, 1'b0, 5'd0, 32'h0, 0);
            expect_ex(3'b101, 7'h20, 32'd5, 32'd4, 5'd3);
        end
        step(1'b1, 32'h00100293, 1'b1, 1'b0, 5'd0, 32'h0, 1);
        expect_ex(3'b000, 7'h00, 32'd0, 32'd1, 5'd5);
        // LW is dropped.
        step(1'b1, 32'h0000A103, 1'b1, 1'b0, 5'd0, 32'h0, 1);
        #1;
        check_eq("dir_lw_ex_valid", 32'(bus.ex_valid), 32'd0);
        check_eq("dir_lw_drop", 32'(drop_cnt), 32'd1);
        expect_pend(2, 1'b1);
        // x0 handling.
        step(1'b1, 32'h00700013, 1'b1, 1'b0, 5'd0, 32'h0, 1);
        expect_pend(0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, -1);
        step(1'b1, 32'h00000233, 1'b0, 1'b0, 5'd0, 32'h0, 1);
        expect_ex(3'b000, 7'h00, 32'd0, 32'd0, 5'd4);
        expect_pend(0, 1'b0);
        // Asynchronous reset while an op is held.
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.ex_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check_eq("rst_pending", dut.pending_q, 32'd0);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            wv = 1'b0;
            wr = 5'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                wv = 1'b1;
                plist.delete();
                for (int i = 1; i < 32; i++) if (m_pend[i]) plist.push_back(5'(i));
                if (plist.size() != 0 && $urandom_range(0, 3) != 0)
                    wr = plist[$urandom_range(0, plist.size() - 1)];
            end
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                 wv, wr, $urandom, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
